// File: rtl/noc_flit_pkg.sv
// ============================================================================
// noc_flit_pkg
// ----------------------------------------------------------------------------
// Flit format shared by the packet splitter and the packet assembler.
//
// A flit carries one byte of a 32-bit word through the mesh. Fields, from
// MSB to LSB:
//   valid (1) | dest (W) | data (8) | pid (P) | src (W) | idx (2)
// where W = $clog2(node_count) and P is the packet id width.
//
// The field offsets depend on W and P. Modules with non-default widths use
// the offset functions below. The localparams and the flit_t struct describe
// the default 8-node, 5-bit-id configuration.
// ============================================================================
package noc_flit_pkg;

    // Widths that do not depend on mesh size.
    localparam int IDX_W   = 2;
    localparam int DATA_W  = 8;
    localparam int WORD_W  = 32;

    // idx and src sit at the bottom of the flit in every configuration.
    localparam int IDX_LSB = 0;
    localparam int SRC_LSB = IDX_LSB + IDX_W;

    // Default configuration: 8 nodes, 5-bit packet id.
    localparam int DEF_NODE_COUNT = 8;
    localparam int DEF_PID_W      = 5;
    localparam int DEF_W          = 3;

    // Total flit width: 2 address fields, packet id, data byte, idx and valid.
    function automatic int flit_width(input int node_count, input int pid_width);
        return 2 * $clog2(node_count) + pid_width + DATA_W + IDX_W + 1;
    endfunction

    function automatic int pid_lsb(input int node_count);
        return SRC_LSB + $clog2(node_count);
    endfunction

    function automatic int data_lsb(input int node_count, input int pid_width);
        return pid_lsb(node_count) + pid_width;
    endfunction

    function automatic int dest_lsb(input int node_count, input int pid_width);
        return data_lsb(node_count, pid_width) + DATA_W;
    endfunction

    function automatic int valid_bit(input int node_count, input int pid_width);
        return dest_lsb(node_count, pid_width) + $clog2(node_count);
    endfunction

    // Packed view of a flit in the default configuration.
    typedef struct packed {
        logic                 valid;
        logic [DEF_W-1:0]     dest;
        logic [DATA_W-1:0]    data;
        logic [DEF_PID_W-1:0] pid;
        logic [DEF_W-1:0]     src;
        logic [IDX_W-1:0]     idx;
    } flit_t;

    // Byte lane placement: idx 0 is the most significant byte of the word.
    function automatic logic [WORD_W-1:0] place_byte(
        input logic [WORD_W-1:0] word,
        input logic [IDX_W-1:0]  idx,
        input logic [DATA_W-1:0] value
    );
        logic [WORD_W-1:0] result;
        result = word;
        unique case (idx)
            2'd0: result[31:24] = value;
            2'd1: result[23:16] = value;
            2'd2: result[15:8]  = value;
            2'd3: result[7:0]   = value;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/packet_assembler_lowest_one.sv
// ============================================================================
// lowest_one
// ----------------------------------------------------------------------------
// Priority encoder that returns the index of the lowest set bit of req.
//
// Parameters:
//   WIDTH  number of request bits (>= 2)
// Ports:
//   req    request vector
//   idx    index of the lowest set bit (0 when none is set)
//   found  1 when at least one bit of req is set
// ============================================================================
module lowest_one #(
    parameter  int WIDTH = 4,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last one written.
    // NOTE: every output of a combinational block gets a default first;
    // any path that leaves one unassigned would infer a latch.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_assembler.sv
// ============================================================================
// packet_assembler
// ----------------------------------------------------------------------------
// Reassembles 32-bit words from byte-wide mesh flits. Each flit carries one
// byte plus (src, pid, idx). Bytes of one packet can arrive in any order and
// packets from different sources can interleave. Up to SLOTS packets can be
// in assembly at once. Completed words go out through a valid/ready output
// register in slot-index order.
//
// Parameters:
//   NODE_COUNT       number of mesh nodes (W = $clog2(NODE_COUNT))
//   NODE_ADDR        address of this node, compared with flit dest
//   PACKET_ID_WIDTH  packet id width (P)
//   SLOTS            number of reassembly slots (power of two, >= 2)
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   ce               clock enable; when low all state holds
//   flit_in          incoming flit: valid|dest|data|pid|src|idx
//   out_data         reassembled word (byte idx 0 in bits 31:24)
//   out_src          node that sent the word
//   out_id           packet id of the word
//   out_valid        out_data/out_src/out_id are valid
//   out_ready        consumer accepts the word this cycle
//   err_misroute     one-cycle pulse: flit dropped, dest is another node
//   err_overflow     one-cycle pulse: flit dropped, no free slot
//   err_dup          one-cycle pulse: byte lane written twice (last one kept)
// ============================================================================
module packet_assembler
    import noc_flit_pkg::*;
#(
    parameter  int                            NODE_COUNT      = 8,
    parameter  logic [$clog2(NODE_COUNT)-1:0] NODE_ADDR       = '0,
    parameter  int                            PACKET_ID_WIDTH = 5,
    parameter  int                            SLOTS           = 4,
    localparam int                            W               = $clog2(NODE_COUNT),
    localparam int                            P               = PACKET_ID_WIDTH,
    localparam int                            FLIT_W          = flit_width(NODE_COUNT, PACKET_ID_WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [FLIT_W-1:0] flit_in,
    output logic [31:0]       out_data,
    output logic [W-1:0]      out_src,
    output logic [P-1:0]      out_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_misroute,
    output logic              err_overflow,
    output logic              err_dup
);

    localparam int SLOT_W   = $clog2(SLOTS);
    localparam int PID_LSB  = pid_lsb(NODE_COUNT);
    localparam int DATA_LSB = data_lsb(NODE_COUNT, PACKET_ID_WIDTH);
    localparam int DEST_LSB = dest_lsb(NODE_COUNT, PACKET_ID_WIDTH);
    localparam int VALID_B  = valid_bit(NODE_COUNT, PACKET_ID_WIDTH);

    // ------------------------------------------------------------------
    // Flit field extraction
    // ------------------------------------------------------------------
    logic              f_valid;
    logic [W-1:0]      f_dest;
    logic [DATA_W-1:0] f_data;
    logic [P-1:0]      f_pid;
    logic [W-1:0]      f_src;
    logic [IDX_W-1:0]  f_idx;

    assign f_valid = flit_in[VALID_B];
    assign f_dest  = flit_in[DEST_LSB +: W];
    assign f_data  = flit_in[DATA_LSB +: DATA_W];
    assign f_pid   = flit_in[PID_LSB +: P];
    assign f_src   = flit_in[SRC_LSB +: W];
    assign f_idx   = flit_in[IDX_LSB +: IDX_W];

    // ------------------------------------------------------------------
    // Slot table
    // ------------------------------------------------------------------
    logic [SLOTS-1:0]  busy_q, busy_d;
    logic [SLOTS-1:0]  done_q, done_d;
    logic [3:0]        mask_q [SLOTS];
    logic [3:0]        mask_d [SLOTS];
    logic [W-1:0]      src_q  [SLOTS];
    logic [W-1:0]      src_d  [SLOTS];
    logic [P-1:0]      pid_q  [SLOTS];
    logic [P-1:0]      pid_d  [SLOTS];
    logic [WORD_W-1:0] data_q [SLOTS];
    logic [WORD_W-1:0] data_d [SLOTS];

    logic misroute_d, overflow_d, dup_d;

    // ------------------------------------------------------------------
    // Slot selection
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0] free_idx, done_idx, match_idx;
    logic              free_found, done_found, match_found;
    logic [SLOTS-1:0]  hit;

    // Released slots are still busy this cycle, so the allocator never
    // sees a slot that is being handed to the output register.
    lowest_one #(.WIDTH(SLOTS)) u_free_sel (
        .req   (~busy_q),
        .idx   (free_idx),
        .found (free_found)
    );

    lowest_one #(.WIDTH(SLOTS)) u_done_sel (
        .req   (done_q),
        .idx   (done_idx),
        .found (done_found)
    );

    // Only open (busy, not done) slots take more bytes. At most one slot
    // can hold a given (src, pid), so a plain scan is enough.
    always_comb begin
        hit         = '0;
        match_idx   = '0;
        match_found = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            hit[i] = busy_q[i] && !done_q[i] && (src_q[i] == f_src) && (pid_q[i] == f_pid);
            if (hit[i]) begin
                match_idx   = SLOT_W'(i);
                match_found = 1'b1;
            end
        end
    end

    // The output register can take a word when it is empty or being drained.
    logic out_free;
    assign out_free = !out_valid || out_ready;

    // ------------------------------------------------------------------
    // Next-state of the slot table
    // ------------------------------------------------------------------
    logic [3:0] new_mask;

    always_comb begin
        busy_d     = busy_q;
        done_d     = done_q;
        mask_d     = mask_q;
        src_d      = src_q;
        pid_d      = pid_q;
        data_d     = data_q;
        misroute_d = 1'b0;
        overflow_d = 1'b0;
        dup_d      = 1'b0;
        new_mask   = '0;

        if (ce) begin
            // Hand the lowest done slot to the output register.
            if (out_free && done_found) begin
                busy_d[done_idx] = 1'b0;
                done_d[done_idx] = 1'b0;
                mask_d[done_idx] = '0;
            end

            if (f_valid) begin
                if (f_dest != NODE_ADDR) begin
                    misroute_d = 1'b1;
                end else if (match_found) begin
                    new_mask          = mask_q[match_idx] | (4'b0001 << f_idx);
                    dup_d             = mask_q[match_idx][f_idx];
                    mask_d[match_idx] = new_mask;
                    data_d[match_idx] = place_byte(data_q[match_idx], f_idx, f_data);
                    done_d[match_idx] = &new_mask;
                end else if (free_found) begin
                    busy_d[free_idx]  = 1'b1;
                    done_d[free_idx]  = 1'b0;
                    mask_d[free_idx]  = 4'b0001 << f_idx;
                    src_d[free_idx]   = f_src;
                    pid_d[free_idx]   = f_pid;
                    data_d[free_idx]  = place_byte(data_q[free_idx], f_idx, f_data);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            done_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                mask_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            mask_q <= mask_d;
        end
    end

    // NOTE: the slot payload is not reset; busy/mask decide whether it is
    // meaningful, and a slot is only read once all four lanes are written.
    always_ff @(posedge clk) begin
        src_q  <= src_d;
        pid_q  <= pid_d;
        data_q <= data_d;
    end

    // Error pulses last one cycle; an edge with ce low clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_misroute <= 1'b0;
            err_overflow <= 1'b0;
            err_dup      <= 1'b0;
        end else begin
            err_misroute <= misroute_d;
            err_overflow <= overflow_d;
            err_dup      <= dup_d;
        end
    end

    // Output register: the payload holds whenever no new word is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_id    <= '0;
        end else if (ce && out_free) begin
            out_valid <= done_found;
            if (done_found) begin
                out_data <= data_q[done_idx];
                out_src  <= src_q[done_idx];
                out_id   <= pid_q[done_idx];
            end
        end
    end

endmodule

// File: tb/tb_packet_assembler.sv
// ============================================================================
// tb_packet_assembler
// ----------------------------------------------------------------------------
// Directed bench for packet_assembler with 8 nodes, local address 4, 5-bit
// packet ids and 4 slots. Inputs change 1 ns after a rising edge and outputs
// are read at the same point.
// ============================================================================
module tb_packet_assembler;
    import noc_flit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [21:0] flit_in;
    logic [31:0] out_data;
    logic [2:0]  out_src;
    logic [4:0]  out_id;
    logic        out_valid;
    logic        out_ready;
    logic        err_misroute;
    logic        err_overflow;
    logic        err_dup;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    packet_assembler #(
        .NODE_COUNT      (8),
        .NODE_ADDR       (3'd4),
        .PACKET_ID_WIDTH (5),
        .SLOTS           (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .flit_in      (flit_in),
        .out_data     (out_data),
        .out_src      (out_src),
        .out_id       (out_id),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err_misroute (err_misroute),
        .err_overflow (err_overflow),
        .err_dup      (err_dup)
    );

    // Present one flit for one edge, then stop driving a valid flit.
    task automatic send(input logic [2:0] dest, input logic [7:0] data,
                        input logic [4:0] pid, input logic [2:0] src,
                        input logic [1:0] idx);
        flit_t f;
        f.valid = 1'b1;
        f.dest  = dest;
        f.data  = data;
        f.pid   = pid;
        f.src   = src;
        f.idx   = idx;
        flit_in = f;
        @(posedge clk);
        #1;
        flit_in = '0;
    endtask

    task automatic idle();
        flit_in = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", out_data); end
        checks++; if (out_src !== 3'd0) begin errors++; $display("FAIL reset_src: got %0d expected 0", out_src); end
        checks++; if (out_id !== 5'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", out_id); end
        checks++; if ({err_misroute, err_overflow, err_dup} !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", {err_misroute, err_overflow, err_dup}); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        send(3'd4, 8'hDE, 5'd5, 3'd2, 2'd0);
        send(3'd4, 8'hAD, 5'd5, 3'd2, 2'd1);
        send(3'd4, 8'hBE, 5'd5, 3'd2, 2'd2);
        send(3'd4, 8'hEF, 5'd5, 3'd2, 2'd3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", out_data); end
        checks++; if (out_src !== 3'd2) begin errors++; $display("FAIL single_src: got %0d expected 2", out_src); end
        checks++; if (out_id !== 5'd5) begin errors++; $display("FAIL single_id: got %0d expected 5", out_id); end
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_interleave();
        logic [1:0] order [4];
        logic [7:0] a_bytes [4];
        logic [7:0] b_bytes [4];
        order   = '{2'd3, 2'd1, 2'd0, 2'd2};
        a_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        b_bytes = '{8'h55, 8'h66, 8'h77, 8'h88};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(3'd4, a_bytes[order[i]], 5'd3, 3'd1, order[i]);
            if (i == 3) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ilv_early_valid: got %b expected 0", out_valid); end
            end
            send(3'd4, b_bytes[order[i]], 5'd3, 3'd6, order[i]);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ilv_first_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'h11223344) begin errors++; $display("FAIL ilv_first_data: got %h expected 11223344", out_data); end
        checks++; if (out_src !== 3'd1) begin errors++; $display("FAIL ilv_first_src: got %0d expected 1", out_src); end
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ilv_second_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'h55667788) begin errors++; $display("FAIL ilv_second_data: got %h expected 55667788", out_data); end
        checks++; if (out_src !== 3'd6) begin errors++; $display("FAIL ilv_second_src: got %0d expected 6", out_src); end
        checks++; if (out_id !== 5'd3) begin errors++; $display("FAIL ilv_second_id: got %0d expected 3", out_id); end
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ilv_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_misroute();
        out_ready = 1'b1;
        send(3'd1, 8'hAA, 5'd7, 3'd2, 2'd0);
        checks++; if (err_misroute !== 1'b1) begin errors++; $display("FAIL misroute_pulse: got %b expected 1", err_misroute); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL misroute_valid: got %b expected 0", out_valid); end
        send(3'd4, 8'hBB, 5'd7, 3'd2, 2'd1);
        checks++; if (err_misroute !== 1'b0) begin errors++; $display("FAIL misroute_one_cycle: got %b expected 0", err_misroute); end
        send(3'd4, 8'hCC, 5'd7, 3'd2, 2'd2);
        send(3'd4, 8'hDD, 5'd7, 3'd2, 2'd3);
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL misroute_table: got %b expected 0", out_valid); end
        send(3'd4, 8'h01, 5'd7, 3'd2, 2'd0);
        checks++; if (err_dup !== 1'b0) begin errors++; $display("FAIL misroute_no_dup: got %b expected 0", err_dup); end
        idle();
        checks++; if (out_data !== 32'h01BBCCDD) begin errors++; $display("FAIL misroute_word: got %h expected 01bbccdd", out_data); end
        idle();
    endtask

    task automatic test_ce();
        ce = 1'b0;
        send(3'd1, 8'h5A, 5'd1, 3'd0, 2'd0);
        checks++; if (err_misroute !== 1'b0) begin errors++; $display("FAIL ce_gate: got %b expected 0", err_misroute); end
        ce = 1'b1;
        idle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(3'd4, 8'h01, 5'd9, 3'd3, 2'd0);
        send(3'd4, 8'h02, 5'd9, 3'd3, 2'd1);
        send(3'd4, 8'h03, 5'd9, 3'd3, 2'd2);
        send(3'd4, 8'h04, 5'd9, 3'd3, 2'd3);
        send(3'd4, 8'h05, 5'd10, 3'd4, 2'd0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b expected 1", out_valid); end
        send(3'd4, 8'h06, 5'd10, 3'd4, 2'd1);
        send(3'd4, 8'h07, 5'd10, 3'd4, 2'd2);
        send(3'd4, 8'h08, 5'd10, 3'd4, 2'd3);
        idle();
        checks++; if (out_data !== 32'h01020304) begin errors++; $display("FAIL bp_hold_data: got %h expected 01020304", out_data); end
        checks++; if (out_src !== 3'd3) begin errors++; $display("FAIL bp_hold_src: got %0d expected 3", out_src); end
        checks++; if (out_id !== 5'd9) begin errors++; $display("FAIL bp_hold_id: got %0d expected 9", out_id); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        idle();
        checks++; if (out_data !== 32'h05060708) begin errors++; $display("FAIL bp_second_data: got %h expected 05060708", out_data); end
        checks++; if (out_src !== 3'd4) begin errors++; $display("FAIL bp_second_src: got %0d expected 4", out_src); end
        checks++; if (out_id !== 5'd10) begin errors++; $display("FAIL bp_second_id: got %0d expected 10", out_id); end
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_overflow_dup();
        out_ready = 1'b1;
        send(3'd4, 8'hA0, 5'd1, 3'd0, 2'd0);
        send(3'd4, 8'hB0, 5'd1, 3'd1, 2'd0);
        send(3'd4, 8'h0C, 5'd1, 3'd2, 2'd0);
        send(3'd4, 8'hD0, 5'd1, 3'd3, 2'd0);
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_fourth: got %b expected 0", err_overflow); end
        send(3'd4, 8'hE0, 5'd1, 3'd5, 2'd0);
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", err_overflow); end
        send(3'd4, 8'h10, 5'd1, 3'd2, 2'd2);
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b expected 0", err_overflow); end
        checks++; if (err_dup !== 1'b0) begin errors++; $display("FAIL dup_first: got %b expected 0", err_dup); end
        send(3'd4, 8'h20, 5'd1, 3'd2, 2'd2);
        checks++; if (err_dup !== 1'b1) begin errors++; $display("FAIL dup_pulse: got %b expected 1", err_dup); end
        send(3'd4, 8'h30, 5'd1, 3'd2, 2'd1);
        checks++; if (err_dup !== 1'b0) begin errors++; $display("FAIL dup_one_cycle: got %b expected 0", err_dup); end
        send(3'd4, 8'h40, 5'd1, 3'd2, 2'd3);
        idle();
        checks++; if (out_data !== 32'h0C302040) begin errors++; $display("FAIL dup_word: got %h expected 0c302040", out_data); end
        checks++; if (out_src !== 3'd2) begin errors++; $display("FAIL dup_src: got %0d expected 2", out_src); end
        send(3'd4, 8'hA1, 5'd1, 3'd0, 2'd1);
        send(3'd4, 8'hA2, 5'd1, 3'd0, 2'd2);
        send(3'd4, 8'hA3, 5'd1, 3'd0, 2'd3);
        idle();
        checks++; if (out_data !== 32'hA0A1A2A3) begin errors++; $display("FAIL ovf_slot0_word: got %h expected a0a1a2a3", out_data); end
        checks++; if (out_src !== 3'd0) begin errors++; $display("FAIL ovf_slot0_src: got %0d expected 0", out_src); end
        idle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(3'd4, 8'h01, 5'd4, 3'd5, 2'd0);
        send(3'd4, 8'h02, 5'd4, 3'd5, 2'd1);
        send(3'd4, 8'h03, 5'd4, 3'd5, 2'd2);
        send(3'd4, 8'h04, 5'd4, 3'd5, 2'd3);
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got %b expected 1", out_valid); end
        send(3'd4, 8'h12, 5'd2, 3'd1, 2'd0);
        send(3'd4, 8'h34, 5'd2, 3'd1, 2'd1);
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 00000000", out_data); end
        checks++; if (out_src !== 3'd0) begin errors++; $display("FAIL rstmid_src: got %0d expected 0", out_src); end
        checks++; if (out_id !== 5'd0) begin errors++; $display("FAIL rstmid_id: got %0d expected 0", out_id); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(3'd4, 8'h12, 5'd2, 3'd1, 2'd0);
        checks++; if (err_dup !== 1'b0) begin errors++; $display("FAIL rstmid_dup0: got %b expected 0", err_dup); end
        send(3'd4, 8'h34, 5'd2, 3'd1, 2'd1);
        checks++; if (err_dup !== 1'b0) begin errors++; $display("FAIL rstmid_dup1: got %b expected 0", err_dup); end
        send(3'd4, 8'h56, 5'd2, 3'd1, 2'd2);
        send(3'd4, 8'h78, 5'd2, 3'd1, 2'd3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early: got %b expected 0", out_valid); end
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_word_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'h12345678) begin errors++; $display("FAIL rstmid_word: got %h expected 12345678", out_data); end
        checks++; if (out_src !== 3'd1) begin errors++; $display("FAIL rstmid_src_after: got %0d expected 1", out_src); end
        checks++; if (out_id !== 5'd2) begin errors++; $display("FAIL rstmid_id_after: got %0d expected 2", out_id); end
        idle();
    endtask

    initial begin
        rst       = 1'b0;
        ce        = 1'b1;
        out_ready = 1'b1;
        flit_in   = '0;
        #1;
        test_reset();
        test_single();
        test_interleave();
        test_misroute();
        test_ce();
        test_backpressure();
        test_overflow_dup();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
